// File: rtl/sim_phase_ctrl_pkg.sv
// Shared definitions for the timestep sequencer: particle/grid geometry,
// the grid address type and the phase enumeration.
package sim_phase_ctrl_pkg;

    localparam int unsigned NUM_PARTICLES = 8;
    localparam int unsigned PADDR_W       = $clog2(NUM_PARTICLES);

    // Grid words per bank; the sweep issues one paired request per two words.
    localparam int unsigned GRID_WORDS = 16;
    localparam int unsigned GADDR_W    = $clog2(GRID_WORDS);
    localparam int unsigned NUM_REQS   = GRID_WORDS / 2;
    localparam int unsigned WIDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef logic [GADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_SC,
        SWEEP,
        DRAIN
    } phase_t;

    // Address of pair member p for word index w, i.e. 2*w + p.
    function automatic addr_t pair_addr(input logic [WIDX_W-1:0] w, input logic p);
        return addr_t'({w, p});
    endfunction

endpackage

// File: rtl/sim_phase_ctrl_valid_delay.sv
// Fixed-latency delay line for a single valid strobe.
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset, clears every stage
//   valid_i  strobe in
//   valid_o  strobe in, delayed LAT cycles (holes preserved)
//   busy_o   high while any strobe is still in flight (including the output stage)
module valid_delay #(
    parameter int unsigned LAT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic valid_o,
    output logic busy_o
);

    logic [LAT-1:0] shreg_q, shreg_d;

    // Truncating cast drops the oldest stage; also covers LAT == 1.
    always_comb begin
        shreg_d = LAT'({shreg_q, valid_i});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign valid_o = shreg_q[LAT-1];
    assign busy_o  = |shreg_q;

endmodule

// File: rtl/sim_phase_ctrl.sv
// Timestep sequencer for the scatterer / charge-grid datapath. Each timestep
// streams all particles into the scatterer, waits for scatter completion,
// sweeps the charge grid with paired read requests and drains the returning
// charge strobes. Being the sole source of valid_scatter and valid_req, it keeps
// scatter and solve off the grid ports at the same time.
// Ports:
//   clk, rst (sync, active-low)
//   start, cfg_steps           run request and timestep count (sampled in IDLE)
//   pmem_raddr, pmem_re        particle memory read port
//   valid_scatter              particle_in valid, PMEM_LAT after pmem_re
//   scatter_done               scatterer finished (honoured in WAIT_SC only)
//   solver_ready               solver accepts a charge pair CHARGE_LAT later
//   valid_req, grid_addr_out   paired grid read request
//   charge_valid               valid_req delayed CHARGE_LAT cycles
//   step_cnt, busy, run_done   progress / status
module sim_phase_ctrl
    import sim_phase_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STEPS_W = 16,
    parameter int unsigned PMEM_LAT    = 2,
    parameter int unsigned CHARGE_LAT  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_STEPS_W-1:0] cfg_steps,
    output logic [PADDR_W-1:0]     pmem_raddr,
    output logic                   pmem_re,
    output logic                   valid_scatter,
    input  logic                   scatter_done,
    input  logic                   solver_ready,
    output logic                   valid_req,
    output addr_t [3:0][1:0]       grid_addr_out,
    output logic                   charge_valid,
    output logic [NUM_STEPS_W-1:0] step_cnt,
    output logic                   busy,
    output logic                   run_done
);

    localparam int unsigned DCNT_W = $clog2(CHARGE_LAT + 1);

    phase_t                 state_q, state_d;
    logic [PADDR_W-1:0]     paddr_q, paddr_d;
    logic [WIDX_W-1:0]      widx_q, widx_d;
    logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
    logic [NUM_STEPS_W-1:0] steps_q, steps_d;
    logic [NUM_STEPS_W-1:0] step_cnt_q, step_cnt_d;
    logic                   run_done_q, run_done_d;

    logic vs_busy, cv_busy;
    logic last_particle, last_word, drain_done, last_step;

    assign last_particle = (paddr_q == PADDR_W'(NUM_PARTICLES - 1));
    assign last_word     = (widx_q == WIDX_W'(NUM_REQS - 1));
    // Counter gives the nominal latency; the pipe check guarantees no strobe is lost.
    assign drain_done    = (dcnt_q == DCNT_W'(CHARGE_LAT)) && !cv_busy;
    assign last_step     = ((step_cnt_q + NUM_STEPS_W'(1)) == steps_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && (cfg_steps != '0)) state_d = ISSUE;
            ISSUE:   if (last_particle) state_d = WAIT_SC;
            WAIT_SC: if (scatter_done && !vs_busy) state_d = SWEEP;
            SWEEP:   if (solver_ready && last_word) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = last_step ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pmem_re       = 1'b0;
        valid_req     = 1'b0;
        grid_addr_out = '0;
        if (state_q == ISSUE) begin
            pmem_re = 1'b1;
        end
        if ((state_q == SWEEP) && solver_ready) begin
            valid_req = 1'b1;
            // Outer index is the lane copy, inner index the pair member.
            for (int j = 0; j < 4; j++) begin
                for (int p = 0; p < 2; p++) begin
                    grid_addr_out[j][p] = pair_addr(widx_q, 1'(p));
                end
            end
        end
    end

    assign pmem_raddr = paddr_q;
    assign step_cnt   = step_cnt_q;
    assign busy       = (state_q != IDLE);
    assign run_done   = run_done_q;

    // Counters and run bookkeeping
    always_comb begin
        paddr_d    = paddr_q;
        widx_d     = widx_q;
        dcnt_d     = '0;
        steps_d    = steps_q;
        step_cnt_d = step_cnt_q;
        run_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    steps_d    = cfg_steps;
                    step_cnt_d = '0;
                    run_done_d = (cfg_steps == '0);
                end
            end
            ISSUE: paddr_d = last_particle ? '0 : paddr_q + PADDR_W'(1);
            SWEEP: begin
                if (solver_ready) begin
                    widx_d = last_word ? '0 : widx_q + WIDX_W'(1);
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    step_cnt_d = step_cnt_q + NUM_STEPS_W'(1);
                    run_done_d = last_step;
                end else if (dcnt_q != DCNT_W'(CHARGE_LAT)) begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end else begin
                    dcnt_d = dcnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            paddr_q    <= '0;
            widx_q     <= '0;
            dcnt_q     <= '0;
            steps_q    <= '0;
            step_cnt_q <= '0;
            run_done_q <= 1'b0;
        end else begin
            paddr_q    <= paddr_d;
            widx_q     <= widx_d;
            dcnt_q     <= dcnt_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
            run_done_q <= run_done_d;
        end
    end

    valid_delay #(
        .LAT(PMEM_LAT)
    ) u_scatter_dly (
        .clk_i  (clk),
        .rst_ni (rst),
        .valid_i(pmem_re),
        .valid_o(valid_scatter),
        .busy_o (vs_busy)
    );

    valid_delay #(
        .LAT(CHARGE_LAT)
    ) u_charge_dly (
        .clk_i  (clk),
        .rst_ni (rst),
        .valid_i(valid_req),
        .valid_o(charge_valid),
        .busy_o (cv_busy)
    );

endmodule
